// File: rtl/sram_line_gather_wr.sv
// Gathers BEATS input beats into one line and writes it to the SRAM macro's port 0.
// Latency: csb0 goes low on the same edge that accepts the closing beat (or a bare flush).
// Backpressure: none; s_ready is held high whenever the block is out of reset.
module sram_line_gather_wr #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 4,
    parameter int BEAT_WIDTH = 64,
    parameter int CNT_WIDTH  = 16,
    localparam int BEATS     = DATA_WIDTH / BEAT_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BEAT_WIDTH-1:0] s_data,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic                  s_flush,
    output logic                  csb0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  lines_written
);

    // Beat counter must be able to hold the value BEATS (full line).
    localparam int CNT_W = $clog2(BEATS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   staging;
    logic [ADDR_WIDTH-1:0]   addr_q;

    logic                    beat_fire;
    logic [CNT_W-1:0]        cnt_next;
    logic [DATA_WIDTH-1:0]   line_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    do_close;

    // Merge the incoming beat into the staging line and decide whether this edge closes it.
    // Staging is cleared on every close, so unfilled beat slots are already zero.
    always_comb begin
        beat_fire = s_valid && s_ready;
        cnt_next  = beat_fire ? cnt + CNT_W'(1) : cnt;
        line_next = staging;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_fire && (cnt == CNT_W'(k))) begin
                line_next[k*BEAT_WIDTH +: BEAT_WIDTH] = s_data;
            end
        end
        // The address is taken only from beat 0 of a line.
        addr_next = (state == IDLE) ? s_addr : addr_q;
        do_close  = (beat_fire && (s_flush || (cnt_next == CNT_W'(BEATS))))
                  || ((state == FILL) && s_flush && !beat_fire);
    end

    // Gather FSM with registered macro-facing outputs; a close frees staging for the next beat.
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state         <= IDLE;
            cnt           <= '0;
            staging       <= '0;
            addr_q        <= '0;
            s_ready       <= 1'b0;
            csb0          <= 1'b1;
            addr0         <= '0;
            din0          <= '0;
            lines_written <= '0;
        end else begin
            s_ready <= 1'b1;
            csb0    <= 1'b1;
            if (do_close) begin
                din0          <= line_next;
                addr0         <= addr_next;
                csb0          <= 1'b0;
                lines_written <= lines_written + CNT_WIDTH'(1);
                staging       <= '0;
                cnt           <= '0;
                state         <= IDLE;
            end else if (beat_fire) begin
                staging <= line_next;
                cnt     <= cnt_next;
                addr_q  <= addr_next;
                state   <= FILL;
            end
        end
    end

    // Busy covers both a partially gathered line and the write cycle itself.
    always_comb begin
        busy = (state == FILL) || !csb0;
    end

endmodule

// File: tb/tb_sram_line_gather_wr.sv
// Scoreboard bench for sram_line_gather_wr: directed scenarios followed by random traffic.
// Driver updates a queue-based line model at each edge; a negedge monitor checks the DUT.
// Counter width is reduced to 2 so wrap-around is exercised by ordinary traffic.
module tb_sram_line_gather_wr;

    localparam int DW = 512;
    localparam int AW = 4;
    localparam int BW = 64;
    localparam int CW = 2;

    logic          clk0 = 1'b0;
    logic          rstb0 = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [BW-1:0] s_data = '0;
    logic [AW-1:0] s_addr = '0;
    logic          s_flush = 1'b0;
    logic          csb0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          busy;
    logic [CW-1:0] lines_written;

    sram_line_gather_wr #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BEAT_WIDTH(BW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk0         (clk0),
        .rstb0        (rstb0),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_addr       (s_addr),
        .s_flush      (s_flush),
        .csb0         (csb0),
        .addr0        (addr0),
        .din0         (din0),
        .busy         (busy),
        .lines_written(lines_written)
    );

    always #5 clk0 = ~clk0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [CW-1:0] n;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] mb[$];       // beats of the line currently being gathered
    logic [AW-1:0] m_addr;
    logic          m_ready = 1'b0;
    logic          m_close = 1'b0;
    int            m_lines = 0;
    logic          mon_en = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_close();
        logic [DW-1:0] line;
        exp_t          e;
        line = '0;
        for (int k = 0; k < mb.size(); k++) line[k*BW +: BW] = mb[k];
        m_lines++;
        e.a = m_addr;
        e.d = line;
        e.n = CW'(m_lines);
        sb.push_back(e);
        mb.delete();
        m_close = 1'b1;
    endtask

    // Drive one cycle of inputs, then advance the model by what the edge should do.
    task automatic step(input logic rst, input logic v, input logic [BW-1:0] d,
                        input logic [AW-1:0] a, input logic f);
        rstb0   = rst;
        s_valid = v;
        s_data  = d;
        s_addr  = a;
        s_flush = f;
        @(posedge clk0);
        m_close = 1'b0;
        if (!rst) begin
            mb.delete();
            m_ready = 1'b0;
            m_lines = 0;
        end else begin
            if (v && m_ready) begin
                if (mb.size() == 0) m_addr = a;
                mb.push_back(d);
                if (f || mb.size() == DW / BW) model_close();
            end else if (f && mb.size() > 0) begin
                model_close();
            end
            m_ready = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: compare the handshake/status outputs every cycle and pop the scoreboard on each write.
    always @(negedge clk0) begin
        if (mon_en) begin
            exp_t e;
            chk("s_ready", {511'b0, s_ready}, {511'b0, m_ready});
            chk("csb0", {511'b0, csb0}, {511'b0, !m_close});
            chk("busy", {511'b0, busy}, {511'b0, (mb.size() > 0) || m_close});
            chk("lines_written", {510'b0, lines_written}, {510'b0, CW'(m_lines)});
            if (csb0 === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: got csb0=0 addr0=%h expected no write", addr0);
                end else begin
                    e = sb.pop_front();
                    chk("addr0", {508'b0, addr0}, {508'b0, e.a});
                    chk("din0", din0, e.d);
                    chk("wr_count", {510'b0, lines_written}, {510'b0, e.n});
                end
            end
        end
    end

    initial begin
        logic [BW-1:0] rd;
        // Reset state
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        mon_en = 1'b1;
        @(negedge clk0);
        #1;
        chk("rst_addr0", {508'b0, addr0}, '0);
        chk("rst_din0", din0, '0);

        // One full line, beat k = k, at address 3
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, BW'(k), (k == 0) ? 4'h3 : 4'hF, 1'b0);
        idle(2);

        // Two lines back-to-back with no gap
        for (int k = 0; k < 16; k++)
            step(1'b1, 1'b1, {$urandom, $urandom}, (k < 8) ? 4'h5 : 4'h9, 1'b0);
        idle(2);

        // Partial line closed by a bare flush after an idle gap
        step(1'b1, 1'b1, 64'hA, 4'h2, 1'b0);
        step(1'b1, 1'b1, 64'hB, 4'h0, 1'b0);
        step(1'b1, 1'b1, 64'hC, 4'h0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, '0, '0, 1'b1);
        idle(2);

        // Flush with every beat: one write per cycle
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, {$urandom, $urandom}, AW'(k), 1'b1);
        idle(2);

        // Reset mid-line discards the partial line
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, {$urandom, $urandom}, 4'h4, 1'b0);
        step(1'b0, 1'b1, '0, '0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, {$urandom, $urandom}, 4'h7, 1'b0);
        idle(2);

        // Flush while idle does nothing; then enough lines to wrap the counter
        step(1'b1, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, {$urandom, $urandom}, AW'(k), 1'b1);
        idle(2);

        // Random traffic with occasional flushes and resets
        for (int i = 0; i < 600; i++) begin
            rd = {$urandom, $urandom};
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rd,
                 AW'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
        end
        idle(3);

        chk("sb_drain", {480'b0, 32'(sb.size())}, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_line_gather_wr.md
Name: sram_line_gather_wr

Overview:
- Upstream write-side stage for the 512-bit x 16-word 0rw1r1w SRAM macro.
- Accepts a stream of 64-bit beats over a valid/ready handshake and gathers 8 consecutive beats into one 512-bit line.
- Issues each completed line as a single write on the macro's port 0 (csb0/addr0/din0).
- Uses a staging register plus an output register, so a sustained 1 beat/clock stream runs with no bubbles.

Parameters:
- DATA_WIDTH, 512, line width; must equal the macro word size.
- ADDR_WIDTH, 4, line address width; must equal the macro address width.
- BEAT_WIDTH, 64, input beat width; DATA_WIDTH must be an integer multiple of it.
- BEATS, DATA_WIDTH/BEAT_WIDTH (8), beats per line; derived, not overridden.
- CNT_WIDTH, 16, width of the completed-line counter.

Ports:
- clk0  input  1  clock; shared with the macro's port 0 clock.
- rstb0  input  1  synchronous active-low reset; sampled on posedge clk0.
- s_valid  input  1  beat valid.
- s_ready  output  1  beat accept; a beat transfers when s_valid && s_ready at posedge.
- s_data  input  BEAT_WIDTH  beat payload.
- s_addr  input  ADDR_WIDTH  line address; sampled only on the first beat of a line.
- s_flush  input  1  close the current line early; missing beats are zero-filled.
- csb0  output  1  active-low write select to the macro; low for exactly one cycle per line.
- addr0  output  ADDR_WIDTH  write address to the macro.
- din0  output  DATA_WIDTH  write data to the macro.
- busy  output  1  high while a partial line is held or a write is pending.
- lines_written  output  CNT_WIDTH  count of lines issued; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rstb0=0 at posedge): s_ready=0, csb0=1, addr0=0, din0=0, busy=0, lines_written=0, beat count=0, staging cleared, state=IDLE.
- s_ready rises on the first posedge with rstb0=1 and stays high at all other times; this stage never backpressures.
- Reset mid-line: any partial line is discarded and no write is issued. A csb0=0 in flight in the same cycle is forced to 1.
- States:
  - IDLE: no partial line held.
  - FILL: 1..BEATS-1 beats held.
- Beat k of a line (k=0..BEATS-1) lands in staging bits [k*BEAT_WIDTH +: BEAT_WIDTH]; beat 0 is the LSBs.
- IDLE, beat accepted: latch s_addr, store beat 0, count=1, go to FILL. If s_flush is also high, close the line immediately; beats 1..7 are zero.
- FILL, beat accepted: store at index=count, count+1. When count reaches BEATS, or s_flush is high with the beat, close the line and go to IDLE.
- FILL, s_flush=1 with s_valid=0: close the line with the remaining beats zero and go to IDLE.
- IDLE, s_flush=1 with s_valid=0: ignored; no write.
- Close: at the same posedge, the staging line (including the beat just accepted) and the latched address load into din0/addr0, and csb0 goes to 0. On the next posedge csb0 returns to 1 unless another close occurs. Latency from the last beat handshake edge to csb0=0 is 0 cycles after that edge. The macro captures on the following posedge.
- Back-to-back: the staging register is free on the close cycle, so beat 0 of the next line may be accepted on the very next cycle. Worst case is one close per cycle (flush with every beat); each close holds csb0 low for its own cycle with new addr0/din0.
- addr0/din0 hold their last values while csb0=1; they are not cleared.
- lines_written increments by 1 on each close edge.
- busy = (state==FILL) || (csb0==0).
- s_data/s_addr are don't-care when not handshaked. s_addr on beats 1..7 is ignored.

Test Plan:
- Reset then 8 beats 64'h0..0 through 64'h..07 (beat k = k), s_addr=4'h3 on beat 0 -> csb0=0 for exactly 1 cycle, addr0=3, din0[63:0]=0 ... din0[511:448]=7, lines_written=1.
- 16 beats continuous, s_addr=5 then 9 -> no s_ready drop; two single-cycle csb0 pulses 8 cycles apart with addr0=5 then 9; lines_written=2.
- 3 beats 0xA,0xB,0xC at addr 2, idle, then s_flush alone -> one write, addr0=2, din0[191:0]=C,B,A, din0[511:192]=0.
- s_flush with every beat at addrs 1,2,3 on consecutive cycles -> csb0 low 3 consecutive cycles, addr0=1,2,3, each din0 holds only its beat 0.
- 5 beats, then rstb0=0 for 1 cycle, then 8 fresh beats at addr 7 -> no write for the first line; one write at addr 7; lines_written=1.
- Count wrap with CNT_WIDTH=2 -> after 5 lines, lines_written=1; s_flush in IDLE -> no csb0 pulse.
